matrix_norm_sequencer: RTL and testbench

- Parametrised successor to the fixed 64x64 column-wise LayerNorm matrix controller.
- Snapshots a DIMxDIM row-major matrix and feeds it one vector at a time to an external vector LayerNorm engine over a start/done handshake.
- The axis is selectable per run: column-wise (one vector per column) or row-wise (one vector per row).
- Adds an abort input, a per-vector completion strobe and a watchdog timeout. Sits between the attention/FFN matrix datapath and the vector engine.

---
 rtl/matrix_norm_sequencer.sv | 155 +++++++++++++++
 tb/tb_matrix_norm_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_norm_sequencer.sv
// matrix_norm_sequencer
// Snapshots a DIM x DIM row-major matrix and streams it, one vector at a time,
// through an external vector LayerNorm engine. The vector axis (column or row)
// is chosen per run. It reassembles the returned vectors into matrix_out_flat.
// A per-vector watchdog ends the run with a sticky error if the engine stalls.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   start, abort     run request (taken only in IDLE), cancel the run
//   axis_sel         0 = column-wise, 1 = row-wise (captured at start)
//   matrix_in_flat   input matrix, element (r,c) at index r*DIM+c
//   ln_x_flat        vector sent to the engine, with a one-cycle ln_start
//   ln_y_flat        engine result, valid while ln_done is high
//   matrix_out_flat  result matrix, same layout as the input
//   vec_valid        pulse: vector vec_idx has been written to the result
//   done             end-of-run pulse (normal or timeout)
//   timeout_err      sticky watchdog flag, cleared by the next accepted start
//   busy             high whenever the sequencer is not idle
module matrix_norm_sequencer #(
   parameter int DIM            = 64,
   parameter int X_WIDTH        = 16,
   parameter int Y_WIDTH        = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         abort,
   input  logic                         axis_sel,
   input  logic [DIM*DIM*X_WIDTH-1:0]   matrix_in_flat,
   output logic [DIM*X_WIDTH-1:0]       ln_x_flat,
   output logic                         ln_start,
   input  logic [DIM*Y_WIDTH-1:0]       ln_y_flat,
   input  logic                         ln_done,
   output logic [DIM*DIM*Y_WIDTH-1:0]   matrix_out_flat,
   output logic                         vec_valid,
   output logic [$clog2(DIM)-1:0]       vec_idx,
   output logic                         done,
   output logic                         timeout_err,
   output logic                         busy
);

   localparam int IW = $clog2(DIM);
   localparam int CW = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t                        state;
   logic [DIM*DIM*X_WIDTH-1:0]    matrix_buf;
   logic                          axis_q;
   logic                          adv;        // vec_idx increment deferred to ISSUE
   logic [CW-1:0]                 wait_cnt;
   logic                          ln_start_q;
   logic                          done_q;

   logic [X_WIDTH-1:0]            buf_e [DIM][DIM];
   logic [IW-1:0]                 sel_idx;
   logic [DIM*X_WIDTH-1:0]        x_sel;
   logic [DIM*DIM*Y_WIDTH-1:0]    out_next;

   // vec_idx keeps the finished index during the vec_valid cycle; the
   // increment lands when the next vector is issued.
   assign sel_idx = vec_idx + IW'(adv);

   genvar r, c;
   for (r = 0; r < DIM; r++) begin : g_row
      for (c = 0; c < DIM; c++) begin : g_col
         logic col_hit, row_hit;
         assign buf_e[r][c] = matrix_buf[(r*DIM+c)*X_WIDTH +: X_WIDTH];
         assign col_hit = !axis_q && (vec_idx == IW'(c));
         assign row_hit =  axis_q && (vec_idx == IW'(r));
         assign out_next[(r*DIM+c)*Y_WIDTH +: Y_WIDTH] =
            col_hit ? ln_y_flat[r*Y_WIDTH +: Y_WIDTH] :
            row_hit ? ln_y_flat[c*Y_WIDTH +: Y_WIDTH] :
                      matrix_out_flat[(r*DIM+c)*Y_WIDTH +: Y_WIDTH];
      end
      assign x_sel[r*X_WIDTH +: X_WIDTH] = axis_q ? buf_e[sel_idx][r] : buf_e[r][sel_idx];
   end

   // Abort must silence the engine start and the done pulse in the very cycle
   // it is raised, so these two are gated after the register.
   assign ln_start = ln_start_q & ~abort;
   assign done     = done_q & ~abort;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         matrix_buf      <= '0;
         axis_q          <= 1'b0;
         adv             <= 1'b0;
         wait_cnt        <= '0;
         ln_start_q      <= 1'b0;
         done_q          <= 1'b0;
         ln_x_flat       <= '0;
         matrix_out_flat <= '0;
         vec_valid       <= 1'b0;
         vec_idx         <= '0;
         timeout_err     <= 1'b0;
      end else begin
         ln_start_q <= 1'b0;
         done_q     <= 1'b0;
         vec_valid  <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  matrix_buf      <= matrix_in_flat;
                  axis_q          <= axis_sel;
                  vec_idx         <= '0;
                  adv             <= 1'b0;
                  matrix_out_flat <= '0;
                  timeout_err     <= 1'b0;
                  state           <= ISSUE;
               end
            end
            ISSUE: begin
               if (abort) begin
                  state <= IDLE;
               end else begin
                  ln_x_flat  <= x_sel;
                  ln_start_q <= 1'b1;
                  wait_cnt   <= '0;
                  vec_idx    <= sel_idx;
                  adv        <= 1'b0;
                  state      <= WAIT;
               end
            end
            WAIT: begin
               if (abort) begin
                  state <= IDLE;
               end else if (ln_done) begin
                  matrix_out_flat <= out_next;
                  vec_valid       <= 1'b1;
                  if (vec_idx == IW'(DIM-1)) begin
                     done_q <= 1'b1;
                     state  <= DONE;
                  end else begin
                     adv   <= 1'b1;
                     state <= ISSUE;
                  end
               end else if (wait_cnt == CW'(TIMEOUT_CYCLES-1)) begin
                  timeout_err <= 1'b1;
                  done_q      <= 1'b1;
                  state       <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_norm_sequencer.sv
// Scoreboard bench for matrix_norm_sequencer (DIM=4, TIMEOUT_CYCLES=16).
// Stimulus pushes expected vec_valid indices and done events; a monitor pops
// and compares them as the DUT presents them. An engine process models the
// vector LayerNorm unit with programmable latency and function.
module tb_matrix_norm_sequencer;
   localparam int DIM = 4;
   localparam int XW  = 16;
   localparam int YW  = 16;
   localparam int TO  = 16;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic                     start = 1'b0;
   logic                     abort = 1'b0;
   logic                     axis_sel = 1'b0;
   logic [DIM*DIM*XW-1:0]    matrix_in_flat = '0;
   logic [DIM*XW-1:0]        ln_x_flat;
   logic                     ln_start;
   logic [DIM*YW-1:0]        ln_y_flat = '0;
   logic                     ln_done = 1'b0;
   logic [DIM*DIM*YW-1:0]    matrix_out_flat;
   logic                     vec_valid;
   logic [1:0]               vec_idx;
   logic                     done;
   logic                     timeout_err;
   logic                     busy;

   matrix_norm_sequencer #(.DIM(DIM), .X_WIDTH(XW), .Y_WIDTH(YW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .axis_sel(axis_sel),
      .matrix_in_flat(matrix_in_flat), .ln_x_flat(ln_x_flat), .ln_start(ln_start),
      .ln_y_flat(ln_y_flat), .ln_done(ln_done), .matrix_out_flat(matrix_out_flat),
      .vec_valid(vec_valid), .vec_idx(vec_idx), .done(done),
      .timeout_err(timeout_err), .busy(busy));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   typedef struct { int cyc; logic terr; } done_t;
   int    exp_vv[$];
   done_t exp_done[$];

   // engine model configuration
   int eng_k = 0, eng_mode = 0, eng_silent = -1, eng_cnt = 0, abort_vec = -1;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] mk_in();
      logic [255:0] m;
      m = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            m[(r*4+c)*16 +: 16] = 16'(16*r + c);
      return m;
   endfunction

   // hand-derived result patterns for each scenario
   function automatic logic [255:0] mk_exp(input int kind);
      logic [255:0] m;
      int v;
      m = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            case (kind)
               0: v = 16*r + c + 1;                  // elementwise +1
               1: v = 16*r + 3 - c;                  // rows reversed
               2: v = 16*(3-r) + c;                  // columns reversed
               3: v = (c == 0) ? 16*r + 1 : 0;       // only column 0 done
               4: v = (c < 2) ? 16*r + c + 1 : 0;    // columns 0,1 done
               default: v = 0;
            endcase
            m[(r*4+c)*16 +: 16] = 16'(v);
         end
      return m;
   endfunction

   function automatic logic [63:0] eng_fn(input logic [63:0] x, input int mode);
      logic [63:0] y;
      for (int i = 0; i < 4; i++)
         y[i*16 +: 16] = (mode == 1) ? x[(3-i)*16 +: 16] : x[i*16 +: 16] + 16'd1;
      return y;
   endfunction

   // engine: answers k cycles after ln_start, optionally goes silent
   initial begin
      forever begin
         @(posedge clk); #1;
         if (ln_start) begin
            if (eng_silent >= 0 && eng_cnt >= eng_silent) begin
               eng_cnt++;
            end else begin
               repeat (eng_k) begin @(posedge clk); #1; end
               ln_y_flat = eng_fn(ln_x_flat, eng_mode);
               ln_done = 1'b1;
               if (abort_vec >= 0 && int'(vec_idx) == abort_vec) abort = 1'b1;
               eng_cnt++;
               @(posedge clk); #1;
               ln_done = 1'b0;
               abort = 1'b0;
            end
         end
      end
   end

   // monitor
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (vec_valid) begin
               if (exp_vv.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_vec_valid actual_idx=%0d required=none", vec_idx);
               end else chk("vec_idx", 256'(vec_idx), 256'(exp_vv.pop_front()));
            end
            if (done) begin
               if (exp_done.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_done cycle=%0d required=none", cyc);
               end else begin
                  done_t e;
                  e = exp_done.pop_front();
                  chk("done_cycle", 256'(cyc), 256'(e.cyc));
                  chk("done_timeout_err", 256'(timeout_err), 256'(e.terr));
               end
            end
         end
      end
   end

   task automatic run_start(input logic ax, input int k, input int mode, input int silent,
                            input int avec, output int s);
      eng_k = k; eng_mode = mode; eng_silent = silent; eng_cnt = 0; abort_vec = avec;
      axis_sel = ax;
      start = 1'b1;
      s = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int n = 0; n < 200; n++) begin
         if (!busy) break;
         @(posedge clk); #1;
      end
      chk(name, 256'(busy), 256'(0));
   endtask

   task automatic push_vv(input int n);
      for (int i = 0; i < n; i++) exp_vv.push_back(i);
   endtask

   task automatic push_done(input int c, input logic t);
      done_t e;
      e.cyc = c; e.terr = t;
      exp_done.push_back(e);
   endtask

   initial begin
      int s;
      logic [255:0] alt;
      matrix_in_flat = mk_in();
      repeat (3) @(posedge clk); #1;
      // reset state
      chk("rst_out", matrix_out_flat, '0);
      chk("rst_ln_x", 256'(ln_x_flat), '0);
      chk("rst_ctrl", 256'({ln_start, vec_valid, vec_idx, done, timeout_err, busy}), '0);
      rst = 1'b0;
      @(posedge clk); #1;

      // column-wise, +1, k=3
      push_vv(4);
      run_start(1'b0, 3, 0, -1, -1, s);
      push_done(s + 21, 1'b0);
      @(posedge clk); #1;
      chk("t1_ln_start", 256'(ln_start), 256'(1));
      chk("t1_first_x", 256'(ln_x_flat), 256'(64'h0030_0020_0010_0000));
      wait_idle("t1_idle");
      chk("t1_out", matrix_out_flat, mk_exp(0));

      // row-wise, reversed, k=0
      push_vv(4);
      run_start(1'b1, 0, 1, -1, -1, s);
      push_done(s + 9, 1'b0);
      @(posedge clk); #1;
      chk("t2_first_x", 256'(ln_x_flat), 256'(64'h0003_0002_0001_0000));
      wait_idle("t2_idle");
      chk("t2_out", matrix_out_flat, mk_exp(1));

      // snapshot: inputs change after start, extra start mid-run
      push_vv(4);
      run_start(1'b0, 1, 1, -1, -1, s);
      push_done(s + 13, 1'b0);
      for (int i = 0; i < 16; i++) alt[i*16 +: 16] = 16'h8000 | 16'(i);
      matrix_in_flat = alt;
      axis_sel = 1'b1;
      repeat (4) @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle("t3_idle");
      chk("t3_out", matrix_out_flat, mk_exp(2));
      matrix_in_flat = mk_in();
      axis_sel = 1'b0;
      repeat (5) @(posedge clk); #1;

      // timeout: engine answers vector 0 only
      push_vv(1);
      run_start(1'b0, 0, 0, 1, -1, s);
      push_done(s + 20, 1'b1);
      wait_idle("t4_idle");
      chk("t4_out", matrix_out_flat, mk_exp(3));
      chk("t4_err_sticky", 256'(timeout_err), 256'(1));

      // abort together with ln_done of vector 2
      push_vv(2);
      run_start(1'b0, 1, 0, -1, 2, s);
      @(posedge clk); #1;
      chk("t5_err_cleared", 256'(timeout_err), 256'(0));
      repeat (7) @(posedge clk); #1;
      chk("t5_busy_abort_cycle", 256'(busy), 256'(1));
      @(posedge clk); #1;
      chk("t5_busy_after_abort", 256'(busy), 256'(0));
      repeat (4) @(posedge clk); #1;
      chk("t5_out", matrix_out_flat, mk_exp(4));

      // fresh run after abort
      push_vv(4);
      run_start(1'b1, 2, 1, -1, -1, s);
      push_done(s + 17, 1'b0);
      wait_idle("t5b_idle");
      chk("t5b_out", matrix_out_flat, mk_exp(1));

      // reset during WAIT of vector 1
      push_vv(1);
      run_start(1'b0, 2, 0, -1, -1, s);
      repeat (5) @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("t6_rst_out", matrix_out_flat, '0);
      chk("t6_rst_ln_x", 256'(ln_x_flat), '0);
      chk("t6_rst_ctrl", 256'({ln_start, vec_valid, vec_idx, done, timeout_err, busy}), '0);
      repeat (3) begin
         @(negedge clk);
         chk("t6_ln_start_in_rst", 256'(ln_start), 256'(0));
      end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) @(posedge clk); #1;
      push_vv(4);
      run_start(1'b1, 0, 0, -1, -1, s);
      push_done(s + 9, 1'b0);
      wait_idle("t6_idle");
      chk("t6_out", matrix_out_flat, mk_exp(0));

      repeat (5) @(posedge clk); #1;
      chk("vv_queue_drained", 256'(exp_vv.size()), 256'(0));
      chk("done_queue_drained", 256'(exp_done.size()), 256'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
